// File: rtl/fft64_pkg.sv
// Shared constants for the 64-point FFT datapath: lane geometry, the W8^1 twiddle
// constant with its rounding helper, and the 3-bit bit-reverse table.
package fft64_pkg;

    localparam int IN_W     = 10;
    localparam int OUT_W    = 13;
    localparam int N_LANES  = 8;
    localparam int TW_C707  = 181;
    localparam int TW_SHIFT = 8;

    localparam logic [2:0] BIT_REV [N_LANES] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    // c*v with c ~ 1/sqrt(2): round half up, arithmetic shift keeps the sign
    function automatic int mul_c707(input int v);
        return (v * TW_C707 + (1 << (TW_SHIFT - 1))) >>> TW_SHIFT;
    endfunction

endpackage

// File: rtl/bfly2.sv
// Radix-2 butterfly (a+b, a-b) on complex operands; outputs grow by one bit.
// With RADIX8_STAGE_SCALE_EN defined each result is halved, rounding half up.
module bfly2 #(
    parameter int W = 10
) (
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    output logic signed [W:0]   sum_re,
    output logic signed [W:0]   sum_im,
    output logic signed [W:0]   diff_re,
    output logic signed [W:0]   diff_im
);

    logic signed [W+1:0] s_re;
    logic signed [W+1:0] s_im;
    logic signed [W+1:0] d_re;
    logic signed [W+1:0] d_im;

    assign s_re = (W+2)'(a_re) + (W+2)'(b_re);
    assign s_im = (W+2)'(a_im) + (W+2)'(b_im);
    assign d_re = (W+2)'(a_re) - (W+2)'(b_re);
    assign d_im = (W+2)'(a_im) - (W+2)'(b_im);

`ifdef RADIX8_STAGE_SCALE_EN
    logic signed [W+1:0] one_c;
    assign one_c   = $signed((W+2)'(1));
    assign sum_re  = (W+1)'((s_re + one_c) >>> 1);
    assign sum_im  = (W+1)'((s_im + one_c) >>> 1);
    assign diff_re = (W+1)'((d_re + one_c) >>> 1);
    assign diff_im = (W+1)'((d_im + one_c) >>> 1);
`else
    assign sum_re  = (W+1)'(s_re);
    assign sum_im  = (W+1)'(s_im);
    assign diff_re = (W+1)'(d_re);
    assign diff_im = (W+1)'(d_im);
`endif

endmodule

// File: rtl/radix8_stage.sv
// 8-point DIT DFT over one lane group per cycle: three registered butterfly ranks,
// group index carried alongside. Optional X/8 scaling via RADIX8_STAGE_SCALE_EN.
module radix8_stage #(
    parameter int IN_W  = fft64_pkg::IN_W,
    parameter int OUT_W = fft64_pkg::OUT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [8*IN_W-1:0]    dinre,
    input  logic [8*IN_W-1:0]    dinim,
    output logic                 out_valid,
    output logic [8*OUT_W-1:0]   doutre,
    output logic [8*OUT_W-1:0]   doutim,
    output logic [2:0]           group_idx,
    output logic                 out_last
);
    import fft64_pkg::*;

    localparam int W1 = IN_W + 1;
    localparam int W2 = IN_W + 2;
    localparam int W3 = IN_W + 3;

    logic signed [IN_W-1:0] x_re [N_LANES];
    logic signed [IN_W-1:0] x_im [N_LANES];
    logic signed [W1-1:0]   r1_re_next [N_LANES], r1_im_next [N_LANES];
    logic signed [W1-1:0]   r1_re_reg  [N_LANES], r1_im_reg  [N_LANES];
    logic signed [W1-1:0]   t2_re [N_LANES], t2_im [N_LANES];
    logic signed [W2-1:0]   r2_re_next [N_LANES], r2_im_next [N_LANES];
    logic signed [W2-1:0]   r2_re_reg  [N_LANES], r2_im_reg  [N_LANES];
    logic signed [W2-1:0]   t3_re [N_LANES], t3_im [N_LANES];
    logic signed [W3-1:0]   r3_re_next [N_LANES], r3_im_next [N_LANES];
    logic signed [W3-1:0]   r3_re_reg  [N_LANES], r3_im_reg  [N_LANES];

    logic [2:0] cnt_reg, idx1_reg, idx2_reg, idx3_reg;
    logic       v1_reg, v2_reg, v3_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign x_re[gi] = dinre[int'(BIT_REV[gi])*IN_W +: IN_W];
            assign x_im[gi] = dinim[int'(BIT_REV[gi])*IN_W +: IN_W];
            // Rank-2 twiddle is -j on lanes 3 and 7: (a+jb)(-j) = b - ja
            if (gi % 4 == 3) begin : g_tw_mj
                assign t2_re[gi] = r1_im_reg[gi];
                assign t2_im[gi] = -r1_re_reg[gi];
            end else begin : g_tw_one
                assign t2_re[gi] = r1_re_reg[gi];
                assign t2_im[gi] = r1_im_reg[gi];
            end
            assign doutre[gi*OUT_W +: OUT_W] = OUT_W'(r3_re_reg[gi]);
            assign doutim[gi*OUT_W +: OUT_W] = OUT_W'(r3_im_reg[gi]);
        end

        for (gi = 0; gi < 4; gi++) begin : g_rank
            localparam int P2 = (gi / 2) * 4 + (gi % 2);

            bfly2 #(.W(IN_W)) u_bf1 (
                .a_re(x_re[2*gi]), .a_im(x_im[2*gi]), .b_re(x_re[2*gi+1]), .b_im(x_im[2*gi+1]),
                .sum_re(r1_re_next[2*gi]), .sum_im(r1_im_next[2*gi]),
                .diff_re(r1_re_next[2*gi+1]), .diff_im(r1_im_next[2*gi+1]));

            bfly2 #(.W(W1)) u_bf2 (
                .a_re(t2_re[P2]), .a_im(t2_im[P2]), .b_re(t2_re[P2+2]), .b_im(t2_im[P2+2]),
                .sum_re(r2_re_next[P2]), .sum_im(r2_im_next[P2]),
                .diff_re(r2_re_next[P2+2]), .diff_im(r2_im_next[P2+2]));

            // Rank-3 twiddle W8^gi on the lower half; upper half passes straight through
            assign t3_re[gi] = r2_re_reg[gi];
            assign t3_im[gi] = r2_im_reg[gi];
            if (gi == 0) begin : g_w0
                assign t3_re[gi+4] = r2_re_reg[gi+4];
                assign t3_im[gi+4] = r2_im_reg[gi+4];
            end else if (gi == 1) begin : g_w1
                assign t3_re[gi+4] = W2'(mul_c707(int'(r2_re_reg[gi+4]) + int'(r2_im_reg[gi+4])));
                assign t3_im[gi+4] = W2'(mul_c707(int'(r2_im_reg[gi+4]) - int'(r2_re_reg[gi+4])));
            end else if (gi == 2) begin : g_w2
                assign t3_re[gi+4] = r2_im_reg[gi+4];
                assign t3_im[gi+4] = -r2_re_reg[gi+4];
            end else begin : g_w3
                assign t3_re[gi+4] = W2'(mul_c707(int'(r2_im_reg[gi+4]) - int'(r2_re_reg[gi+4])));
                assign t3_im[gi+4] = W2'(-mul_c707(int'(r2_re_reg[gi+4]) + int'(r2_im_reg[gi+4])));
            end

            bfly2 #(.W(W2)) u_bf3 (
                .a_re(t3_re[gi]), .a_im(t3_im[gi]), .b_re(t3_re[gi+4]), .b_im(t3_im[gi+4]),
                .sum_re(r3_re_next[gi]), .sum_im(r3_im_next[gi]),
                .diff_re(r3_re_next[gi+4]), .diff_im(r3_im_next[gi+4]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            idx1_reg <= '0;
            idx2_reg <= '0;
            idx3_reg <= '0;
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            v3_reg   <= 1'b0;
            for (int i = 0; i < N_LANES; i++) begin
                r1_re_reg[i] <= '0;
                r1_im_reg[i] <= '0;
                r2_re_reg[i] <= '0;
                r2_im_reg[i] <= '0;
                r3_re_reg[i] <= '0;
                r3_im_reg[i] <= '0;
            end
        end else begin
            v1_reg <= in_valid;
            v2_reg <= v1_reg;
            v3_reg <= v2_reg;
            // Stages only load on a valid group, so outputs hold across gaps
            if (in_valid) begin
                cnt_reg   <= cnt_reg + 3'd1;
                idx1_reg  <= cnt_reg;
                r1_re_reg <= r1_re_next;
                r1_im_reg <= r1_im_next;
            end
            if (v1_reg) begin
                idx2_reg  <= idx1_reg;
                r2_re_reg <= r2_re_next;
                r2_im_reg <= r2_im_next;
            end
            if (v2_reg) begin
                idx3_reg  <= idx2_reg;
                r3_re_reg <= r3_re_next;
                r3_im_reg <= r3_im_next;
            end
        end
    end

    assign out_valid = v3_reg;
    assign group_idx = idx3_reg;
    assign out_last  = v3_reg && (idx3_reg == 3'd7);

endmodule

// File: tb/tb_radix8_stage.sv
// Scoreboard bench for radix8_stage: directed DFT vectors, frame/last timing,
// asynchronous reset mid-frame, then randomized groups against a generic FFT model.
module tb_radix8_stage;

    localparam int IN_W  = 10;
    localparam int OUT_W = 13;

    typedef int lanes_t [8];
    typedef struct packed {
        logic [8*OUT_W-1:0] re;
        logic [8*OUT_W-1:0] im;
        logic [2:0]         idx;
        int                 due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic [8*IN_W-1:0]  dinre = '0;
    logic [8*IN_W-1:0]  dinim = '0;
    logic               out_valid;
    logic [8*OUT_W-1:0] doutre;
    logic [8*OUT_W-1:0] doutim;
    logic [2:0]         group_idx;
    logic               out_last;

    exp_t sb[$];
    int   last_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   grp_cnt = 0;
    int   last_issue = 0;
    int   frame_start = 0;
    bit   frame_mode = 1'b0;

    radix8_stage #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .dinre(dinre), .dinim(dinim),
        .out_valid(out_valid), .doutre(doutre), .doutim(doutim),
        .group_idx(group_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: textbook iterative radix-2 DIT over bit-reversed input,
    // with the W8 rotations expressed directly from their complex definitions.
    function automatic int c707(input int v);
        return (181 * v + 128) >>> 8;
    endfunction

    function automatic int rank_scale(input int v);
`ifdef RADIX8_STAGE_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic void rotate(input int e, input int a, input int b, output int r, output int i);
        case (e)
            0:       begin r = a;            i = b;             end
            1:       begin r = c707(a + b);  i = c707(b - a);   end
            2:       begin r = b;            i = -a;            end
            default: begin r = c707(b - a);  i = -c707(a + b);  end
        endcase
    endfunction

    function automatic void fft8(input lanes_t xr, input lanes_t xi, output lanes_t yr, output lanes_t yi);
        int rv, t, b, br, bi, tr, ti;
        for (int n = 0; n < 8; n++) begin
            rv = ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
            yr[n] = xr[rv];
            yi[n] = xi[rv];
        end
        for (int span = 1; span < 8; span = span * 2)
            for (int base = 0; base < 8; base += 2 * span)
                for (int j = 0; j < span; j++) begin
                    t = base + j;
                    b = t + span;
                    rotate(j * 4 / span, yr[b], yi[b], br, bi);
                    tr = yr[t];
                    ti = yi[t];
                    yr[t] = rank_scale(tr + br);
                    yi[t] = rank_scale(ti + bi);
                    yr[b] = rank_scale(tr - br);
                    yi[b] = rank_scale(ti - bi);
                end
    endfunction

    function automatic logic [8*OUT_W-1:0] pack_out(input lanes_t v);
        logic [8*OUT_W-1:0] p;
        for (int k = 0; k < 8; k++) p[k*OUT_W +: OUT_W] = OUT_W'(v[k]);
        return p;
    endfunction

    task automatic issue(input lanes_t xr, input lanes_t xi, input lanes_t er, input lanes_t ei);
        exp_t e;
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            dinre[n*IN_W +: IN_W] = IN_W'(xr[n]);
            dinim[n*IN_W +: IN_W] = IN_W'(xi[n]);
        end
        in_valid = 1'b1;
        e.re  = pack_out(er);
        e.im  = pack_out(ei);
        e.idx = 3'(grp_cnt);
        e.due = cyc + 3;
        sb.push_back(e);
        last_issue = cyc;
        grp_cnt = (grp_cnt + 1) % 8;
    endtask

    task automatic issue_model(input lanes_t xr, input lanes_t xi);
        lanes_t er, ei;
        fft8(xr, xi, er, ei);
        issue(xr, xi, er, ei);
    endtask

    task automatic directed(input lanes_t xr, input lanes_t xi, input lanes_t er, input lanes_t ei);
`ifdef RADIX8_STAGE_SCALE_EN
        issue_model(xr, xi);
`else
        issue(xr, xi, er, ei);
`endif
    endtask

    task automatic issue_random();
        lanes_t xr, xi;
        for (int n = 0; n < 8; n++) begin
            xr[n] = int'($urandom_range(0, 510)) - 255;
            xi[n] = int'($urandom_range(0, 510)) - 255;
        end
        issue_model(xr, xi);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 128'(sb.size()), 128'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 128'(out_valid), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("out grp %0d cycle %0d re %0h im %0h", group_idx, cyc, doutre, doutim);
                check("doutre", 128'(doutre), 128'(e.re));
                check("doutim", 128'(doutim), 128'(e.im));
                check("group_idx", 128'(group_idx), 128'(e.idx));
                check("out_last", 128'(out_last), 128'(e.idx == 3'd7));
                check("latency", 128'(cyc), 128'(e.due));
            end
            if (frame_mode && out_last) last_cyc.push_back(cyc - frame_start);
        end
    end

    initial begin
        lanes_t z, xr, xi, er, ei;
        z = '{default: 0};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_group_idx", 128'(group_idx), 128'(0));
        check("rst_dout", 128'({doutre, doutim}), 128'(0));
        rst_n = 1'b1;

        // Frame 0: impulse, DC, twiddle, extreme, then random; gap of 2; frame 1 random
        frame_mode = 1'b1;
        xr = z; xr[0] = 100;
        er = '{default: 100};
        directed(xr, z, er, z);
        frame_start = last_issue;

        xr = '{default: 100};
        er = z;
`ifdef RADIX8_STAGE_SCALE_EN
        er[0] = 100;
`else
        er[0] = 800;
`endif
        issue(xr, z, er, z);

        xr = z; xr[1] = 256;
        er = '{256, 181, 0, -181, -256, -181, 0, 181};
        ei = '{0, -181, -256, -181, 0, 181, 256, 181};
        directed(xr, z, er, ei);

        xr = '{default: -512};
        er = z; er[0] = -4096;
        directed(xr, z, er, z);

        repeat (4) issue_random();
        idle(2);
        repeat (8) issue_random();
        drain();
        frame_mode = 1'b0;
        check("last_count", 128'(last_cyc.size()), 128'(2));
        if (last_cyc.size() == 2) begin
            check("last_cycle_0", 128'(last_cyc[0]), 128'(10));
            check("last_cycle_1", 128'(last_cyc[1]), 128'(20));
        end

        // Reset with groups 1..3 still in flight; they must vanish
        repeat (4) issue_random();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 128'(out_valid), 128'(0));
        check("async_rst_idx", 128'(group_idx), 128'(0));
        check("async_rst_dout", 128'({doutre, doutim}), 128'(0));
        sb.delete();
        grp_cnt = 0;
        @(negedge clk) in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        issue_random();
        drain();

        // Randomized groups with occasional gaps
        for (int g = 0; g < 60; g++) begin
            issue_random();
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
